// File: rtl/reg_file_hs_pkg.sv
// Shared constants for the handshaked register file.
// Opcode and func3 encodings used by the extension logic, plus the ecall FSM state type.
package reg_file_hs_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_IO = 1'b1
  } state_e;

endpackage

// File: rtl/reg_file_hs_ext_unit.sv
// Byte/half extension unit (purely combinational).
// Ports:
//   data_i    - value to extend
//   func3_i   - width/sign selector of the memory instruction
//   is_load_i - 1: load extension (b/h/bu/hu), 0: store narrowing (b/h only)
//   data_o    - extended value; unsupported func3 passes data_i through
module reg_file_hs_ext_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      func3_i,
  input  logic            is_load_i,
  output logic [XLEN-1:0] data_o
);
  import reg_file_hs_pkg::*;

  always_comb begin
    data_o = data_i;
    case (func3_i)
      F3_B:    data_o = {{(XLEN-8){data_i[7]}}, data_i[7:0]};
      F3_H:    data_o = {{(XLEN-16){data_i[15]}}, data_i[15:0]};
      F3_BU:   if (is_load_i) data_o = {{(XLEN-8){1'b0}}, data_i[7:0]};
      F3_HU:   if (is_load_i) data_o = {{(XLEN-16){1'b0}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/reg_file_hs.sv
// Integer register file with write-to-read bypass, load extension, store narrowing on port 2,
// mapped tube/LED views and a handshaked ecall input path that stalls until the I/O unit
// supplies a0 (optionally timing out).
// Ports:
//   clk, reset (async, active low), stop_flag (freezes all state)
//   R_reg_1/R_reg_2 -> R_data_1/R_data_2 : combinational reads (port 2 store-narrowed)
//   W_reg, W_data, W_en, opcode, func3   : writeback port
//   io_data, io_valid / io_req, stall, io_timeout : ecall input handshake
//   reg_map_tube, reg_map_led            : raw views of registers TUBE_IDX / LED_IDX
module reg_file_hs #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned A0_IDX     = 10,
  parameter int unsigned TUBE_IDX   = 2**ADDR_W-1,
  parameter int unsigned LED_IDX    = 2**ADDR_W-2,
  parameter int unsigned IO_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop_flag,
  input  logic [ADDR_W-1:0] R_reg_1,
  input  logic [ADDR_W-1:0] R_reg_2,
  input  logic [ADDR_W-1:0] W_reg,
  input  logic [XLEN-1:0]   W_data,
  input  logic              W_en,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   io_data,
  input  logic              io_valid,
  output logic              io_req,
  output logic              stall,
  output logic              io_timeout,
  output logic [XLEN-1:0]   R_data_1,
  output logic [XLEN-1:0]   R_data_2,
  output logic [XLEN-1:0]   reg_map_tube,
  output logic [XLEN-1:0]   reg_map_led
);
  import reg_file_hs_pkg::*;

  localparam int unsigned Depth     = 2**ADDR_W;
  localparam int unsigned CntW      = (IO_TIMEOUT > 2) ? $clog2(IO_TIMEOUT) : 1;
  localparam bit          TimeoutEn = (IO_TIMEOUT > 0);
  localparam logic [CntW-1:0]   CntMax = TimeoutEn ? CntW'(IO_TIMEOUT - 1) : '0;
  localparam logic [ADDR_W-1:0] A0     = ADDR_W'(A0_IDX);
  localparam logic [ADDR_W-1:0] Tube   = ADDR_W'(TUBE_IDX);
  localparam logic [ADDR_W-1:0] Led    = ADDR_W'(LED_IDX);

  logic [XLEN-1:0] regs_q [Depth];
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  logic [XLEN-1:0] ld_ext, w_val, raw_1, raw_2, st_ext;
  logic            wr_norm, ecall_go, io_done, io_tmo, waiting;

  reg_file_hs_ext_unit #(.XLEN(XLEN)) u_ld_ext (
    .data_i    (W_data),
    .func3_i   (func3),
    .is_load_i (1'b1),
    .data_o    (ld_ext)
  );

  assign w_val   = (opcode == OP_LOAD) ? ld_ext : W_data;
  assign waiting = (state_q == ST_WAIT_IO);

  assign wr_norm  = W_en && (W_reg != '0) && !stop_flag && (opcode != OP_ECALL) && !waiting;
  assign ecall_go = W_en && (opcode == OP_ECALL) && !stop_flag && !waiting;
  assign io_done  = waiting && io_valid && !stop_flag;
  // io_valid takes priority over an expiring timeout on the same edge.
  assign io_tmo   = TimeoutEn && waiting && !io_valid && !stop_flag && (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ecall_go) begin
          state_d = ST_WAIT_IO;
          cnt_d   = '0;
        end
      end
      ST_WAIT_IO: begin
        if (io_done) begin
          state_d = ST_IDLE;
        end else if (io_tmo) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else if (!stop_flag && TimeoutEn && (cnt_q != CntMax)) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (wr_norm) begin
        regs_q[W_reg] <= w_val;
      end else if (io_done) begin
        regs_q[A0] <= io_data;
      end else if (io_tmo) begin
        regs_q[A0] <= '0;
      end
    end
  end

  always_comb begin
    raw_1 = regs_q[R_reg_1];
    if (R_reg_1 == '0) begin
      raw_1 = '0;
    end else if (wr_norm && (W_reg == R_reg_1)) begin
      raw_1 = w_val;
    end else if (waiting && io_valid && (R_reg_1 == A0)) begin
      raw_1 = io_data;
    end
  end

  always_comb begin
    raw_2 = regs_q[R_reg_2];
    if (R_reg_2 == '0) begin
      raw_2 = '0;
    end else if (wr_norm && (W_reg == R_reg_2)) begin
      raw_2 = w_val;
    end else if (waiting && io_valid && (R_reg_2 == A0)) begin
      raw_2 = io_data;
    end
  end

  reg_file_hs_ext_unit #(.XLEN(XLEN)) u_st_ext (
    .data_i    (raw_2),
    .func3_i   (func3),
    .is_load_i (1'b0),
    .data_o    (st_ext)
  );

  assign R_data_1     = raw_1;
  assign R_data_2     = (opcode == OP_STORE) ? st_ext : raw_2;
  assign io_req       = waiting;
  assign stall        = waiting;
  assign io_timeout   = timeout_q;
  assign reg_map_tube = regs_q[Tube];
  assign reg_map_led  = regs_q[Led];

endmodule

// File: tb/tb_reg_file_hs.sv
// Self-checking bench for reg_file_hs. Two instances share all inputs: dut waits forever
// for io_valid, dut_t times out after 4 waiting edges. Expectations are queued while
// stimulus is driven and popped/compared once outputs have settled.
module tb_reg_file_hs;
  import reg_file_hs_pkg::*;

  localparam logic [6:0] OP_R = 7'b0110011;

  logic        clk, reset, stop_flag, W_en, io_valid;
  logic [4:0]  R_reg_1, R_reg_2, W_reg;
  logic [31:0] W_data, io_data;
  logic [6:0]  opcode;
  logic [2:0]  func3;

  logic        req, stall, tmo, req_t, stall_t, tmo_t;
  logic [31:0] r1, r2, tube, led, r1_t, r2_t, tube_t, led_t;

  reg_file_hs dut (
    .clk(clk), .reset(reset), .stop_flag(stop_flag),
    .R_reg_1(R_reg_1), .R_reg_2(R_reg_2), .W_reg(W_reg), .W_data(W_data), .W_en(W_en),
    .opcode(opcode), .func3(func3), .io_data(io_data), .io_valid(io_valid),
    .io_req(req), .stall(stall), .io_timeout(tmo),
    .R_data_1(r1), .R_data_2(r2), .reg_map_tube(tube), .reg_map_led(led)
  );

  reg_file_hs #(.IO_TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset), .stop_flag(stop_flag),
    .R_reg_1(R_reg_1), .R_reg_2(R_reg_2), .W_reg(W_reg), .W_data(W_data), .W_en(W_en),
    .opcode(opcode), .func3(func3), .io_data(io_data), .io_valid(io_valid),
    .io_req(req_t), .stall(stall_t), .io_timeout(tmo_t),
    .R_data_1(r1_t), .R_data_2(r2_t), .reg_map_tube(tube_t), .reg_map_led(led_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    S_R1, S_R2, S_TUBE, S_LED, S_STALL, S_REQ, S_TO,
    S_R1T, S_R2T, S_TUBET, S_LEDT, S_STALLT, S_REQT, S_TOT
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [2:0]  ld_f3  [5] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
  logic [31:0] ld_exp [5] = '{32'hFFFF_FFF0, 32'hFFFF_80F0, 32'h0000_00F0, 32'h0000_80F0,
                              32'h0000_80F0};

  function automatic logic [31:0] obs(input sig_e s);
    case (s)
      S_R1:     obs = r1;
      S_R2:     obs = r2;
      S_TUBE:   obs = tube;
      S_LED:    obs = led;
      S_STALL:  obs = {31'd0, stall};
      S_REQ:    obs = {31'd0, req};
      S_TO:     obs = {31'd0, tmo};
      S_R1T:    obs = r1_t;
      S_R2T:    obs = r2_t;
      S_TUBET:  obs = tube_t;
      S_LEDT:   obs = led_t;
      S_STALLT: obs = {31'd0, stall_t};
      S_REQT:   obs = {31'd0, req_t};
      S_TOT:    obs = {31'd0, tmo_t};
      default:  obs = 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
  endtask

  task automatic expect_v(input string tag, input sig_e s, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sig = s;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    #1;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      chk_eq(x.tag, obs(x.sig), x.exp);
    end
  endtask

  // Advance one rising edge; returns at the following falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d, input logic [6:0] op,
                    input logic [2:0] f3);
    W_en = 1'b1; W_reg = idx; W_data = d; opcode = op; func3 = f3;
    tick();
    W_en = 1'b0; opcode = OP_R; func3 = 3'b000;
  endtask

  task automatic ecall_edge();
    W_en = 1'b1; W_reg = 5'd0; opcode = OP_ECALL; func3 = 3'b000;
    tick();
    W_en = 1'b0; opcode = OP_R;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; stop_flag = 1'b0; W_en = 1'b0; io_valid = 1'b0;
    R_reg_1 = 5'd10; R_reg_2 = 5'd31; W_reg = 5'd0; W_data = '0; io_data = '0;
    opcode = OP_R; func3 = 3'b000;
    tick(); tick();

    // Reset state
    expect_v("rst_stall", S_STALL, 0);   expect_v("rst_req", S_REQ, 0);
    expect_v("rst_to", S_TO, 0);         expect_v("rst_r1", S_R1, 0);
    expect_v("rst_r2", S_R2, 0);         expect_v("rst_tube", S_TUBE, 0);
    expect_v("rst_led", S_LED, 0);       expect_v("rst_stall_t", S_STALLT, 0);
    expect_v("rst_req_t", S_REQT, 0);    expect_v("rst_to_t", S_TOT, 0);
    expect_v("rst_r2_t", S_R2T, 0);      expect_v("rst_tube_t", S_TUBET, 0);
    expect_v("rst_led_t", S_LEDT, 0);
    drain();
    reset = 1'b1;
    tick();

    // Fill mapped registers, then reset mid-run
    wr(5'd31, 32'hAAAA_5555, OP_R, 3'b000);
    wr(5'd30, 32'h0000_00FF, OP_R, 3'b000);
    wr(5'd5, 32'h0000_0011, OP_R, 3'b000);
    R_reg_1 = 5'd5;
    expect_v("map_tube", S_TUBE, 32'hAAAA_5555);
    expect_v("map_led", S_LED, 32'h0000_00FF);
    expect_v("map_led_t", S_LEDT, 32'h0000_00FF);
    expect_v("wr_x5", S_R1, 32'h0000_0011);
    drain();
    reset = 1'b0;
    expect_v("mid_rst_r1", S_R1, 0);     expect_v("mid_rst_r2", S_R2, 0);
    expect_v("mid_rst_tube", S_TUBE, 0); expect_v("mid_rst_led", S_LED, 0);
    drain();
    tick();
    reset = 1'b1;
    tick();

    // x0 is hardwired to zero, including on the bypass path
    W_en = 1'b1; W_reg = 5'd0; W_data = 32'hDEAD_BEEF; opcode = OP_R; R_reg_1 = 5'd0;
    expect_v("x0_bypass", S_R1, 0);
    drain();
    tick();
    W_en = 1'b0;
    expect_v("x0_after", S_R1, 0);
    drain();

    // Load extension: bypass value during the write, stored value afterwards
    R_reg_1 = 5'd5;
    for (int i = 0; i < 5; i++) begin
      W_en = 1'b1; W_reg = 5'd5; W_data = 32'h0000_80F0; opcode = OP_LOAD; func3 = ld_f3[i];
      expect_v($sformatf("ld_byp_f3_%0d", ld_f3[i]), S_R1, ld_exp[i]);
      drain();
      tick();
      W_en = 1'b0; opcode = OP_R; func3 = 3'b000;
      expect_v($sformatf("ld_reg_f3_%0d", ld_f3[i]), S_R1, ld_exp[i]);
      drain();
    end

    // Bypass with store narrowing on port 2 only
    W_en = 1'b1; W_reg = 5'd7; W_data = 32'h1234_5680; opcode = OP_STORE; func3 = F3_B;
    R_reg_1 = 5'd7; R_reg_2 = 5'd7;
    expect_v("sb_byp_r2", S_R2, 32'hFFFF_FF80);
    expect_v("sb_byp_r1", S_R1, 32'h1234_5680);
    drain();
    tick();
    W_en = 1'b0; opcode = OP_R; func3 = 3'b000;
    expect_v("st_stored", S_R2, 32'h1234_5680);
    drain();
    tick();
    opcode = OP_STORE; func3 = F3_H;
    expect_v("sh_r2", S_R2, 32'h0000_5680);
    expect_v("sh_r1", S_R1, 32'h1234_5680);
    drain();
    tick();
    opcode = OP_STORE; func3 = 3'b010;
    expect_v("sw_r2", S_R2, 32'h1234_5680);
    drain();
    tick();
    opcode = OP_R;

    // Ecall handshake; io_valid lands on dut_t's timeout edge (tie)
    wr(5'd3, 32'h0000_0033, OP_R, 3'b000);
    W_en = 1'b1; opcode = OP_ECALL;
    expect_v("ecall_pre_stall", S_STALL, 0);
    drain();
    tick();
    W_en = 1'b1; opcode = OP_R; W_reg = 5'd3; W_data = 32'h0000_0BAD; R_reg_1 = 5'd3;
    expect_v("ecall_stall", S_STALL, 1);   expect_v("ecall_req", S_REQ, 1);
    expect_v("ecall_stall_t", S_STALLT, 1); expect_v("ecall_req_t", S_REQT, 1);
    expect_v("wait_no_byp", S_R1, 32'h0000_0033);
    drain();
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_v($sformatf("wait_x3_%0d", i), S_R1, 32'h0000_0033);
      expect_v($sformatf("wait_stall_%0d", i), S_STALL, 1);
      drain();
    end
    W_en = 1'b0; io_valid = 1'b1; io_data = 32'h0000_002A; R_reg_1 = 5'd10;
    expect_v("io_byp", S_R1, 32'h0000_002A);
    expect_v("io_byp_t", S_R1T, 32'h0000_002A);
    drain();
    tick();
    io_valid = 1'b0;
    expect_v("io_stall", S_STALL, 0);     expect_v("io_stall_t", S_STALLT, 0);
    expect_v("tie_no_to", S_TOT, 0);      expect_v("io_x10", S_R1, 32'h0000_002A);
    expect_v("tie_x10_t", S_R1T, 32'h0000_002A);
    drain();
    tick();
    R_reg_1 = 5'd3;
    expect_v("io_x3_kept", S_R1, 32'h0000_0033);
    drain();

    // Timeout on the 4th waiting edge of dut_t; dut keeps waiting
    ecall_edge();
    R_reg_1 = 5'd10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      expect_v($sformatf("to_pulse_%0d", k), S_TOT, 32'(k == 4));
      expect_v($sformatf("to_stall_%0d", k), S_STALLT, 32'(k != 4));
      expect_v($sformatf("nto_stall_%0d", k), S_STALL, 1);
      drain();
    end
    expect_v("to_x10_t", S_R1T, 0);
    drain();
    tick();
    expect_v("to_pulse_end", S_TOT, 0);
    io_valid = 1'b1; io_data = 32'h0000_0055;
    expect_v("rel_byp", S_R1, 32'h0000_0055);
    expect_v("idle_io_ign_byp", S_R1T, 0);
    drain();
    tick();
    io_valid = 1'b0;
    expect_v("rel_x10", S_R1, 32'h0000_0055);
    expect_v("idle_io_ign", S_R1T, 0);
    expect_v("rel_stall", S_STALL, 0);
    drain();

    // Freeze: stop_flag holds state and counter
    ecall_edge();
    tick(); tick();
    stop_flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      expect_v($sformatf("frz_to_%0d", i), S_TOT, 0);
      expect_v($sformatf("frz_stall_%0d", i), S_STALLT, 1);
      drain();
    end
    stop_flag = 1'b0;
    tick();
    expect_v("resume_to_0", S_TOT, 0);
    expect_v("resume_stall_0", S_STALLT, 1);
    drain();
    tick();
    expect_v("resume_to_1", S_TOT, 1);
    expect_v("resume_stall_1", S_STALLT, 0);
    drain();
    io_valid = 1'b1; io_data = 32'h0000_0077;
    tick();
    io_valid = 1'b0;
    expect_v("frz_rel_x10", S_R1, 32'h0000_0077);
    expect_v("frz_rel_stall", S_STALL, 0);
    drain();

    // Asynchronous reset while waiting
    ecall_edge();
    tick();
    expect_v("pre_rst_stall", S_STALL, 1);
    expect_v("pre_rst_stall_t", S_STALLT, 1);
    drain();
    reset = 1'b0;
    expect_v("arst_stall", S_STALL, 0);   expect_v("arst_req", S_REQ, 0);
    expect_v("arst_stall_t", S_STALLT, 0); expect_v("arst_req_t", S_REQT, 0);
    expect_v("arst_x10", S_R1, 0);        expect_v("arst_x10_t", S_R1T, 0);
    drain();
    tick();
    reset = 1'b1;
    tick();
    expect_v("post_rst_stall", S_STALL, 0);
    expect_v("post_rst_x10", S_R1, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_hs.md
Name: reg_file_hs

Overview:
- Parametrised successor to the core's integer register file.
- Provides two combinational read ports with write-to-read bypass and one write port with load byte/half extension.
- Store-operand narrowing and mapped tube/LED outputs are parametrised.
- Adds a handshaked ecall input path: a small FSM stalls the pipeline until the I/O unit supplies data for a0, with an optional timeout.
- Sits between decode/writeback and the I/O controller in the single-cycle CPU.

Parameters:
XLEN, 32, data width of every register
ADDR_W, 5, register index width; depth = 2**ADDR_W
A0_IDX, 10, register written by an ecall input
TUBE_IDX, 2**ADDR_W-1, register mirrored on reg_map_tube
LED_IDX, 2**ADDR_W-2, register mirrored on reg_map_led
IO_TIMEOUT, 0, cycles to wait for io_valid; 0 = wait forever

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
stop_flag  in  1  freeze: no register or FSM update while high
R_reg_1  in  ADDR_W  read index, port 1
R_reg_2  in  ADDR_W  read index, port 2
W_reg  in  ADDR_W  write index
W_data  in  XLEN  writeback data
W_en  in  1  write enable
opcode  in  7  opcode of the instruction in writeback/decode
func3  in  3  func3 of the same instruction
io_data  in  XLEN  ecall input data from the I/O unit
io_valid  in  1  io_data valid (single-cycle pulse or level)
io_req  out  1  ecall input request, held high while waiting
stall  out  1  pipeline stall while an ecall is pending
io_timeout  out  1  one-cycle pulse when a wait times out
R_data_1  out  XLEN  read data, port 1
R_data_2  out  XLEN  read data, port 2 (store-narrowed)
reg_map_tube  out  XLEN  register TUBE_IDX
reg_map_led  out  XLEN  register LED_IDX

Behaviour:
- Reset (reset low, asynchronous):
  - all registers go to 0; FSM goes to IDLE; timeout counter goes to 0.
  - io_req, stall and io_timeout go to 0; mapped outputs and read data read 0.
  - Reset during WAIT_IO abandons the request with no a0 write.
- Write-value computation:
  - Opcode LOAD (0000011): func3 000 gives sext byte; 001 gives sext half; 100 gives zext byte; 101 gives zext half. Any other func3 writes W_data unchanged.
  - Any other opcode writes W_data unchanged.
- Normal write:
  - Occurs on the rising clk edge when W_en=1, W_reg!=0, stop_flag=0, opcode!=ECALL and state=IDLE.
  - Writes to register 0 are dropped; register 0 always reads 0.
- Reads are combinational:
  - An index of 0 returns 0.
  - Bypass: if a normal write to the same nonzero index is being committed this cycle, return the extended write value.
  - In WAIT_IO with io_valid=1, a read of A0_IDX returns io_data.
- Store narrowing on port 2 only, when opcode is STORE (0100011): func3 000 gives sext byte; 001 gives sext half; any other func3 passes through. Port 1 is never narrowed.
- FSM states: IDLE and WAIT_IO.
  - IDLE -> WAIT_IO: on an edge with W_en=1, opcode=ECALL (1110011) and stop_flag=0. The counter clears.
  - WAIT_IO, io_valid=1: the edge writes io_data into A0_IDX and returns to IDLE.
  - WAIT_IO, IO_TIMEOUT>0 and counter = IO_TIMEOUT-1 without io_valid: the edge writes 0 into A0_IDX, pulses io_timeout for 1 cycle and returns to IDLE.
  - WAIT_IO otherwise: the counter increments, saturating at IO_TIMEOUT-1.
  - stop_flag=1 holds the state and the counter; io_req and stall stay asserted.
- io_req and stall equal (state==WAIT_IO), registered.
  - Latency: ecall edge -> stall high from the next cycle.
  - io_valid edge -> stall low in the next cycle; a0 is readable the same cycle via bypass.
- Simultaneous events:
  - In WAIT_IO, W_en is ignored; the pipeline is stalled and the caller must hold its inputs.
  - io_valid and timeout on the same edge: io_valid wins and no timeout pulse is generated.
  - io_valid while in IDLE is ignored.
- Mapped outputs are continuous views of the register contents after the last edge; they carry no bypass.

Decomposition:
- Shared package/header (extends parameters.v):
  - Opcode constants: OP_LOAD, OP_STORE, OP_ECALL.
  - func3 constants: F3_B, F3_H, F3_BU, F3_HU.
  - FSM state encodings: ST_IDLE, ST_WAIT_IO.
- One sub-module, ext_unit: purely combinational. It takes data, func3 and a mode bit (load/store) and returns the extended value. It is instantiated twice: write path and port-2 narrowing.

Test Plan:
- Reset then read: reset low mid-run with registers nonzero -> all R_data, reg_map_tube and reg_map_led = 0; write x0=0xDEADBEEF -> x0 still reads 0.
- Load extension: write x5 with W_data=0x000080F0 and LOAD.
  - lb -> 0xFFFFFFF0; lbu -> 0x000000F0.
  - lh -> 0xFFFF80F0; lhu -> 0x000080F0.
- Bypass and store narrowing: W_reg=7, R_reg_2=7, W_data=0x1234_5680, OP_STORE with sb on the same cycle -> R_data_2=0xFFFFFF80 combinationally; R_data_1 with R_reg_1=7 -> 0x12345680.
- Ecall handshake:
  - Ecall edge -> stall=1, io_req=1 next cycle.
  - Three idle cycles with W_en=1/W_reg=3 -> x3 unchanged.
  - io_valid with io_data=0x2A -> R_data_1 (R_reg_1=10) = 0x2A that cycle; stall=0 the next cycle; x10=0x2A.
- Timeout with IO_TIMEOUT=4: ecall with no io_valid -> io_timeout pulses on the 4th waiting edge, x10=0, stall drops.
- Timeout tie and freeze:
  - io_valid coincident with the timeout edge -> x10=io_data and no pulse.
  - stop_flag high for 10 cycles in WAIT_IO -> no timeout; the counter resumes afterwards.
- Reset mid-wait: reset asserted in WAIT_IO -> stall/io_req=0 immediately (asynchronous); x10=0.
